// File: rtl/softplus_inv_bisect.sv
// ----------------------------------------------------------------------------
// softplus_inv_bisect
//   Inverse of the piecewise-linear softplus used on the VAE decoder side.
//   For a Q8.8 signed target y, returns the smallest Q8.8 x with f(x) >= y,
//   found by a 16-step sequential bisection over the whole signed 16-bit range.
//
// Ports
//   clock      in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   in_valid   in   1      y is valid
//   in_ready   out  1      block can accept y (high only in IDLE)
//   y          in   WIDTH  target softplus value, Q8.8 signed
//   out_valid  out  1      x / underflow are valid (high only in DONE)
//   out_ready  in   1      consumer accepts the result
//   x          out  WIDTH  result, Q8.8 signed
//   underflow  out  1      y <= 0; x is then 0x8000
// ----------------------------------------------------------------------------
module softplus_inv_bisect #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             underflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_r;
  logic signed [15:0] y_r;
  logic signed [15:0] lo_r;
  logic signed [15:0] hi_r;
  logic [3:0]         it_r;

  logic signed [16:0] sum_s;
  logic signed [15:0] mid_s;
  logic signed [15:0] fmid_s;
  logic signed [15:0] lo_nxt_s;
  logic signed [15:0] hi_nxt_s;

  // Piecewise-linear softplus; 21-bit signed intermediates keep every product exact.
  function automatic logic signed [15:0] softplus_f(input logic signed [15:0] r);
    logic signed [20:0] re;
    logic signed [20:0] p;
    re = {{5{r[15]}}, r};
    if (re < -21'sd1024) begin
      p = 21'sd0;
    end else if (re < -21'sd512) begin
      p = (re + 21'sd1024) >>> 4;
    end else if (re < 21'sd0) begin
      p = 21'sd32 + (((re + 21'sd512) * 21'sd9) >>> 5);
    end else if (re < 21'sd512) begin
      p = 21'sd176 + ((re * 21'sd23) >>> 5);
    end else if (re < 21'sd1024) begin
      p = 21'sd544 + (((re - 21'sd512) * 21'sd15) >>> 4);
    end else begin
      p = re;
    end
    return p[15:0];
  endfunction

  // Bisection step: midpoint (17-bit sum avoids overflow) and next search window.
  always_comb begin
    sum_s    = {lo_r[15], lo_r} + {hi_r[15], hi_r};
    mid_s    = sum_s[16:1];
    fmid_s   = softplus_f(mid_s);
    lo_nxt_s = lo_r;
    hi_nxt_s = hi_r;
    if (lo_r < hi_r) begin
      if (fmid_s >= y_r) begin
        hi_nxt_s = mid_s;
      end else begin
        lo_nxt_s = mid_s + 16'sd1;
      end
    end else begin
      lo_nxt_s = lo_r;
      hi_nxt_s = hi_r;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x         <= 16'h0000;
      underflow <= 1'b0;
      y_r       <= 16'sh0000;
      lo_r      <= 16'sh0000;
      hi_r      <= 16'sh0000;
      it_r      <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            y_r      <= y;
            lo_r     <= 16'sh8000;
            hi_r     <= 16'sh7FFF;
            it_r     <= 4'd0;
            in_ready <= 1'b0;
            state_r  <= SEARCH;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SEARCH: begin
          lo_r <= lo_nxt_s;
          hi_r <= hi_nxt_s;
          it_r <= it_r + 4'd1;
          // The last step can still move lo, so the result takes the updated value.
          if (it_r == 4'd15) begin
            x         <= lo_nxt_s;
            underflow <= (y_r <= 16'sd0);
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softplus_inv_bisect.sv
// ----------------------------------------------------------------------------
// tb_softplus_inv_bisect
//   Scoreboard bench: the driver pushes expected results when a y is
//   accepted; an independent monitor pops and compares on every output
//   handshake. Directed vectors carry hand-computed x; sweep vectors are
//   checked against a bench model of f (minimality property).
// ----------------------------------------------------------------------------
module tb_softplus_inv_bisect;

  logic        clock;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic        underflow;

  typedef struct {
    int          yv;
    logic [15:0] xe;
    logic        ue;
    bit          exact;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  softplus_inv_bisect #(.WIDTH(16)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .underflow (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference softplus, written directly from the segment table.
  function automatic int fm(input int r);
    if (r < -1024)     return 0;
    else if (r < -512) return (r + 1024) >>> 4;
    else if (r < 0)    return 32 + (((r + 512) * 9) >>> 5);
    else if (r < 512)  return 176 + ((r * 23) >>> 5);
    else if (r < 1024) return 544 + (((r - 512) * 15) >>> 4);
    else               return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Present y and wait (bounded) until it is taken; optionally push expectation.
  task automatic send(input int yv, input logic [15:0] xe, input logic ue,
                      input bit exact, input bit lat, input bit push);
    exp_t e;
    int   n;
    @(posedge clock); #1;
    in_valid = 1'b1;
    y        = yv[15:0];
    n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (push) begin
      e.yv = yv; e.xe = xe; e.ue = ue; e.exact = exact; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic sweep(input int yv);
    send(yv, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    int   xi;
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {16'd0, x}, 32'hFFFF_FFFF);
      end else begin
        e  = q.pop_front();
        xi = int'($signed(x));
        if (e.exact) begin
          chk("x", {16'd0, x}, {16'd0, e.xe});
          chk("underflow", {31'd0, underflow}, {31'd0, e.ue});
        end else begin
          chk("f_x_ge_y", {31'd0, (fm(xi) >= e.yv)}, 32'd1);
          chk("x_minimal", {31'd0, (xi == -32768) || (fm(xi - 1) < e.yv)}, 32'd1);
          chk("sweep_underflow", {31'd0, underflow}, {31'd0, (e.yv <= 0)});
        end
        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd17);
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    y         = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_x", {16'd0, x}, 32'h0000);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    @(negedge clock);
    rst = 1'b1;

    // Directed vectors with hand-computed results.
    send(32'sh00B0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    send(32'sh0400, 16'h0400, 1'b0, 1'b1, 1'b1, 1'b1);
    send(32'sh1000, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'sh0001, 16'hFC10, 1'b0, 1'b1, 1'b0, 1'b1);
    send(-256,      16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(0,         16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(-32768,    16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(32'sh7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Back-pressure: hold DONE, offer a new y that must not be taken.
    out_ready = 1'b0;
    send(32'sh1000, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clock);
        n++;
      end
    end
    chk("stall_reached_done", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    y        = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_x", {16'd0, x}, 32'h1000);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("release_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset in the middle of a search (it = 7): no result may appear.
    send(32'sh7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clock);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_x", {16'd0, x}, 32'h0000);
    chk("midrst_underflow", {31'd0, underflow}, 32'd0);
    @(negedge clock);
    rst = 1'b1;
    repeat (20) @(negedge clock);
    chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
    send(32'sh0400, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Dense sweep over the curved region, then a coarse sweep of the full range.
    for (int v = -16; v <= 1100; v++) sweep(v);
    for (int v = -32768; v <= 32767; v += 127) sweep(v);
    sweep(32767);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
